// File: rtl/period_to_freq.sv
`default_nettype none
// ============================================================================
// Module   : period_to_freq
// Purpose  : Sequential radix-2 restoring divider that converts a period in
//            milliseconds into a frequency (DIVIDEND / prd, mHz by default).
//            One quotient bit per clock; Q_W steps per conversion.
//
// Ports    : clk        - clock, all logic on the rising edge
//            reset      - asynchronous, active-high reset
//            prd_valid  - one-cycle strobe from the period counter
//            prd        - period in ms, sampled when prd_valid is accepted
//            ready      - high while idle; prd_valid only accepted then
//            done_tick  - one-cycle pulse, freq/err valid
//            freq       - registered quotient, held until next done_tick
//            err        - registered, 1 if the last accepted prd was 0
//
// Options  : PERIOD_TO_FREQ_ROUND_EN - when defined, the dividend is
//            DIVIDEND + (prd >> 1), giving a round-to-nearest quotient.
//            Otherwise the quotient is truncated (floor).
//
// Revision : 1.0 - initial release
// ============================================================================
module period_to_freq #(
  parameter int DIVIDEND = 1_000_000,
  parameter int PRD_W    = 10,
  parameter int Q_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prd_valid,
  input  logic [PRD_W-1:0] prd,
  output logic             ready,
  output logic             done_tick,
  output logic [Q_W-1:0]   freq,
  output logic             err
);

  localparam int             c_CNT_W    = $clog2(Q_W + 1);
  localparam logic [Q_W-1:0] c_DIVIDEND = Q_W'(DIVIDEND);
  localparam logic [Q_W-1:0] c_ALL_ONES = {Q_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Divider datapath registers
  logic [PRD_W-1:0]   r_dvsr;   // divisor
  logic [PRD_W:0]     r_rem;    // partial remainder
  logic [Q_W-1:0]     r_dvd;    // dividend, shifts out MSB-first; quotient shifts in
  logic [c_CNT_W-1:0] r_cnt;    // remaining restoring steps
  logic [Q_W-1:0]     r_freq;
  logic               r_err;

  logic               w_prd_zero;
  logic [Q_W-1:0]     w_ld_dividend;
  logic [PRD_W:0]     w_rem_sh;
  logic               w_ge;
  logic [PRD_W:0]     w_rem_nx;
  logic [Q_W-1:0]     w_quo_nx;
  logic               w_last;

  assign w_prd_zero = (prd == '0);

`ifdef PERIOD_TO_FREQ_ROUND_EN
  // Adding half the divisor before a floor division rounds to nearest.
  assign w_ld_dividend = c_DIVIDEND + Q_W'(prd >> 1);
`else
  assign w_ld_dividend = c_DIVIDEND;
`endif

  // One restoring step: bring the next dividend bit into the remainder,
  // subtract the divisor if it fits.  The bit shifted out of the top of the
  // remainder also counts toward "fits", keeping the compare exact for any
  // remainder value the register can hold.
  assign w_rem_sh = {r_rem[PRD_W-1:0], r_dvd[Q_W-1]};
  assign w_ge     = r_rem[PRD_W] | (w_rem_sh >= {1'b0, r_dvsr});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh;
  assign w_quo_nx = {r_dvd[Q_W-2:0], w_ge};
  assign w_last   = (r_cnt == c_CNT_W'(1));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    ready      = 1'b0;
    done_tick  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (prd_valid) begin
          w_state_nx = w_prd_zero ? S_DONE : S_OP;
        end
      end
      S_OP: begin
        if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done_tick  = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers.  freq/err are only written on the
  // transition into DONE, so they hold steady everywhere else.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvsr <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_cnt  <= '0;
      r_freq <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (prd_valid) begin
            if (w_prd_zero) begin
              r_freq <= c_ALL_ONES;
              r_err  <= 1'b1;
            end else begin
              r_dvsr <= prd;
              r_dvd  <= w_ld_dividend;
              r_rem  <= '0;
              r_cnt  <= c_CNT_W'(Q_W);
            end
          end
        end
        S_OP: begin
          r_rem <= w_rem_nx;
          r_dvd <= w_quo_nx;
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (w_last) begin
            r_freq <= w_quo_nx;
            r_err  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign freq = r_freq;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_period_to_freq.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_to_freq
// Purpose  : Self-checking bench for period_to_freq.  Expected frequencies
//            come from plain integer division in ref_freq(); timing is
//            checked against the fixed latency of the divider.
//            Build with PERIOD_TO_FREQ_ROUND_EN to test the rounding build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_period_to_freq;

  localparam int PRD_W = 10;
  localparam int Q_W   = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             prd_valid;
  logic [PRD_W-1:0] prd;
  logic             ready;
  logic             done_tick;
  logic [Q_W-1:0]   freq;
  logic             err;

  int n_pass  = 0;
  int n_total = 0;

  period_to_freq #(
    .DIVIDEND(1_000_000),
    .PRD_W   (PRD_W),
    .Q_W     (Q_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .prd_valid(prd_valid),
    .prd      (prd),
    .ready    (ready),
    .done_tick(done_tick),
    .freq     (freq),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic from the frequency definition.
  function automatic logic [Q_W-1:0] ref_freq(input int p);
    longint num;
    if (p == 0) return {Q_W{1'b1}};
    num = 1_000_000;
`ifdef PERIOD_TO_FREQ_ROUND_EN
    num = num + p / 2;
`endif
    return Q_W'(num / p);
  endfunction

  function automatic int ref_lat(input int p);
    return (p == 0) ? 1 : Q_W + 1;
  endfunction

  // Issue one strobe and follow it to done_tick.  lat counts clock cycles
  // from the strobe cycle to the done_tick cycle (-1 on timeout).
  task automatic run_div(input int p, output int lat, output bit busy_ok,
                         output bit after_ok);
    logic [Q_W-1:0] f0;
    logic           e0;
    @(negedge clk);
    f0        = freq;
    e0        = err;
    prd_valid = 1'b1;
    prd       = PRD_W'(p);
    lat       = -1;
    busy_ok   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      prd_valid = 1'b0;
      if (done_tick === 1'b1) begin
        lat = n;
        break;
      end
      if (ready !== 1'b0 || freq !== f0 || err !== e0) busy_ok = 1'b0;
    end
    if (ready !== 1'b0) busy_ok = 1'b0;
    @(posedge clk); #1;
    after_ok = (ready === 1'b1 && done_tick === 1'b0);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    prd_valid = 1'b0;
    prd       = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
    n_total++; if (done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", done_tick); else n_pass++;
    n_total++; if (freq !== '0) $display("FAIL reset_freq: got %0d want 0", freq); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit b_ok, a_ok;
    run_div(1, lat, b_ok, a_ok);
    n_total++; if (lat !== 21) $display("FAIL basic_latency: got %0d want 21", lat); else n_pass++;
    n_total++; if (freq !== 20'd1_000_000) $display("FAIL basic_freq: got %0d want 1000000", freq); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
    n_total++; if (b_ok !== 1'b1) $display("FAIL basic_busy_ready: got %b want 1", b_ok); else n_pass++;
    n_total++; if (a_ok !== 1'b1) $display("FAIL basic_ready_return: got %b want 1", a_ok); else n_pass++;
  endtask

  task automatic test_rounding();
    int lat; bit b_ok, a_ok;
    logic [Q_W-1:0] want6, want1023;
`ifdef PERIOD_TO_FREQ_ROUND_EN
    want6 = 20'd166_667; want1023 = 20'd978;
`else
    want6 = 20'd166_666; want1023 = 20'd977;
`endif
    run_div(6, lat, b_ok, a_ok);
    n_total++; if (freq !== want6) $display("FAIL prd6_freq: got %0d want %0d", freq, want6); else n_pass++;
    run_div(1023, lat, b_ok, a_ok);
    n_total++; if (freq !== want1023) $display("FAIL prd1023_freq: got %0d want %0d", freq, want1023); else n_pass++;
    n_total++; if (lat !== 21) $display("FAIL prd1023_latency: got %0d want 21", lat); else n_pass++;
  endtask

  task automatic test_zero();
    int lat; bit b_ok, a_ok;
    run_div(0, lat, b_ok, a_ok);
    n_total++; if (lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (freq !== 20'hFFFFF) $display("FAIL zero_freq: got %h want fffff", freq); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL zero_err: got %b want 1", err); else n_pass++;
    n_total++; if (a_ok !== 1'b1) $display("FAIL zero_ready_return: got %b want 1", a_ok); else n_pass++;
    run_div(500, lat, b_ok, a_ok);
    n_total++; if (freq !== 20'd2000) $display("FAIL p500_freq: got %0d want 2000", freq); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL p500_err: got %b want 0", err); else n_pass++;
  endtask

  // Strobe while busy and strobe coincident with done_tick: both dropped.
  task automatic test_busy_strobe();
    int n_done;
    logic [Q_W-1:0] f_done;
    n_done = 0;
    f_done = '0;
    @(negedge clk);
    prd_valid = 1'b1;
    prd       = PRD_W'(4);
    @(posedge clk); #1;
    prd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    prd_valid = 1'b1;
    prd       = PRD_W'(2);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      prd_valid = 1'b0;
      if (done_tick === 1'b1) begin
        n_done++;
        f_done = freq;
        if (n_done == 1) begin
          prd_valid = 1'b1;
          prd       = PRD_W'(7);
        end
      end
    end
    n_total++; if (n_done !== 1) $display("FAIL busy_done_count: got %0d want 1", n_done); else n_pass++;
    n_total++; if (f_done !== ref_freq(4)) $display("FAIL busy_freq: got %0d want %0d", f_done, ref_freq(4)); else n_pass++;
    n_total++; if (freq !== ref_freq(4)) $display("FAIL busy_freq_held: got %0d want %0d", freq, ref_freq(4)); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL busy_ready_idle: got %b want 1", ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_done, lat; bit b_ok, a_ok;
    n_done = 0;
    @(negedge clk);
    prd_valid = 1'b1;
    prd       = PRD_W'(3);
    @(posedge clk); #1;
    prd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (freq !== '0) $display("FAIL midrst_freq: got %0d want 0", freq); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", ready); else n_pass++;
    n_total++; if (done_tick !== 1'b0) $display("FAIL midrst_done: got %b want 0", done_tick); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL midrst_err: got %b want 0", err); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done_tick === 1'b1) n_done++;
    end
    n_total++; if (n_done !== 0) $display("FAIL midrst_no_done: got %0d want 0", n_done); else n_pass++;
    run_div(2, lat, b_ok, a_ok);
    n_total++; if (freq !== 20'd500_000) $display("FAIL midrst_after_freq: got %0d want 500000", freq); else n_pass++;
    n_total++; if (lat !== 21) $display("FAIL midrst_after_latency: got %0d want 21", lat); else n_pass++;
  endtask

  task automatic test_random();
    int p, lat; bit b_ok, a_ok;
    for (int i = 0; i < 24; i++) begin
      p = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
      run_div(p, lat, b_ok, a_ok);
      n_total++; if (freq !== ref_freq(p)) $display("FAIL rand_freq prd=%0d: got %0d want %0d", p, freq, ref_freq(p)); else n_pass++;
      n_total++; if (err !== (p == 0)) $display("FAIL rand_err prd=%0d: got %b want %b", p, err, (p == 0)); else n_pass++;
      n_total++; if (lat !== ref_lat(p)) $display("FAIL rand_latency prd=%0d: got %0d want %0d", p, lat, ref_lat(p)); else n_pass++;
      n_total++; if ((b_ok & a_ok) !== 1'b1) $display("FAIL rand_handshake prd=%0d: got %b want 1", p, b_ok & a_ok); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_zero();
    test_busy_strobe();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
